// File: rtl/bump_maneuver_sequencer_if.sv
// Signal bundle between the robot board and the bump maneuver sequencer.
// The board side (master) drives run and the raw bumper pins. The sequencer
// side (slave) drives the motor lines, the status outputs and the debug view.
//
// Signalling: there is no valid/ready handshake on this bundle. All signals
// are plain levels.
// - R_bump/L_bump are raw active-low switch levels, asynchronous to clk.
// - run is a level enable sampled on clk.
// - Every output is a level decoded from registered state, plus run for the
//   enables.
interface bump_maneuver_sequencer_if;
    logic       run;
    logic       R_bump;
    logic       L_bump;
    logic       Le;
    logic       Re;
    logic       Ldir;
    logic       Rdir;
    logic       busy;
    logic [7:0] maneuver_cnt;
    // debug view of the sequencer FSM and arbitration state
    logic [1:0] dbg_state;
    logic       dbg_pending;
    logic       dbg_pend_side;   // 0 = right, 1 = left
    logic       dbg_ptr;         // priority pointer, 0 = right, 1 = left

    modport master (
        output run, R_bump, L_bump,
        input  Le, Re, Ldir, Rdir, busy, maneuver_cnt,
        input  dbg_state, dbg_pending, dbg_pend_side, dbg_ptr
    );

    modport slave (
        input  run, R_bump, L_bump,
        output Le, Re, Ldir, Rdir, busy, maneuver_cnt,
        output dbg_state, dbg_pending, dbg_pend_side, dbg_ptr
    );
endinterface

// File: rtl/bump_maneuver_sequencer.sv
// Bump maneuver sequencer.
// - Synchronises and debounces two active-low bumpers.
// - Arbitrates left/right hits.
// - Times a reverse-then-turn maneuver in whole ticks of an internal divider.
// Optional feature macro: MANEUVER_COUNT_EN. When defined, maneuver_cnt counts
// completed maneuvers and saturates at 255. When undefined, maneuver_cnt is 0.
module bump_maneuver_sequencer #(
    parameter int TICK_DIV   = 20800,
    parameter int BACK_TICKS = 50,
    parameter int TURN_TICKS = 40,
    parameter int DEB_CYCLES = 2080
) (
    input  logic                            clk,
    input  logic                            reset,
    bump_maneuver_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BACK   = 2'd1,
        S_TURN_L = 2'd2,
        S_TURN_R = 2'd3
    } state_t;

    localparam int   DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int   DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam logic SIDE_R = 1'b0;
    localparam logic SIDE_L = 1'b1;

    // index 0 = right bumper, index 1 = left bumper
    logic [1:0]       r_sync_r;
    logic [1:0]       r_sync_l;
    logic [1:0]       w_sync;
    logic [DEB_W-1:0] r_deb_cnt [2];
    logic [1:0]       r_evt;
    logic [1:0]       r_evt_d;
    logic [1:0]       w_req;
    logic             w_any;
    logic             w_both;
    logic             w_win;

    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_tcnt;
    logic             w_tick;
    logic [7:0]       w_tick_goal;
    logic             w_phase_end;
    logic             w_entry;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_side;
    logic             w_side_nx;
    logic             r_pending;
    logic             w_pending_nx;
    logic             r_pend_side;
    logic             w_pend_side_nx;
    logic             r_ptr;
    logic             w_ptr_nx;
    logic             r_busy;
    logic             r_armed;

    // two-flop synchronisers; idle level of a released switch is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_r <= 2'b11;
            r_sync_l <= 2'b11;
        end else begin
            r_sync_r <= {r_sync_r[0], bus.R_bump};
            r_sync_l <= {r_sync_l[0], bus.L_bump};
        end
    end

    assign w_sync = {r_sync_l[1], r_sync_r[1]};

    // per-side debounce: count consecutive low samples, flag at DEB_CYCLES
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
            r_evt        <= '0;
            r_evt_d      <= '0;
        end else begin
            r_evt_d <= r_evt;
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i]) begin
                    r_deb_cnt[i] <= '0;
                    r_evt[i]     <= 1'b0;
                end else begin
                    if (r_deb_cnt[i] != DEB_W'(DEB_CYCLES))
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1))
                        r_evt[i] <= 1'b1;
                end
            end
        end
    end

    // one request per press; presses seen while run=0 are dropped
    assign w_req  = r_evt & ~r_evt_d & {2{bus.run}};
    assign w_any  = |w_req;
    assign w_both = &w_req;
    assign w_win  = w_both ? r_ptr : (w_req[1] ? SIDE_L : SIDE_R);

    assign w_tick      = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_tick_goal = (r_state == S_BACK) ? 8'(BACK_TICKS - 1) : 8'(TURN_TICKS - 1);
    assign w_phase_end = w_tick && (r_tcnt == w_tick_goal);
    assign w_entry     = (w_state_nx != r_state);

    // tick divider and phase-tick counter, both restarted on every phase entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= '0;
            r_tcnt <= '0;
        end else if (w_entry) begin
            r_div  <= '0;
            r_tcnt <= '0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_tcnt <= r_tcnt + 8'd1;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // next-state, side latch, pending slot and priority pointer
    always_comb begin
        w_state_nx     = r_state;
        w_side_nx      = r_side;
        w_pending_nx   = r_pending;
        w_pend_side_nx = r_pend_side;
        w_ptr_nx       = r_ptr;
        if (!bus.run) begin
            w_state_nx   = S_IDLE;
            w_pending_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        w_state_nx = S_BACK;
                        w_side_nx  = w_win;
                        if (w_both) begin
                            w_pending_nx   = 1'b1;
                            w_pend_side_nx = ~w_win;
                            w_ptr_nx       = ~r_ptr;
                        end
                    end
                end
                S_BACK: begin
                    if (w_phase_end)
                        w_state_nx = (r_side == SIDE_R) ? S_TURN_L : S_TURN_R;
                end
                default: begin
                    if (w_phase_end) begin
                        if (r_pending) begin
                            w_state_nx   = S_BACK;
                            w_side_nx    = r_pend_side;
                            w_pending_nx = 1'b0;
                        end else begin
                            w_state_nx   = S_IDLE;
                        end
                    end
                end
            endcase
            // hits during a maneuver land in the 1-deep pending slot (latest wins)
            if ((r_state != S_IDLE) && w_any) begin
                w_pending_nx   = 1'b1;
                w_pend_side_nx = w_win;
                if (w_both)
                    w_ptr_nx = ~r_ptr;
            end
        end
    end

    // state register with arbitration bookkeeping and registered busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_side      <= SIDE_R;
            r_pending   <= 1'b0;
            r_pend_side <= SIDE_R;
            r_ptr       <= SIDE_R;
            r_busy      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_side      <= w_side_nx;
            r_pending   <= w_pending_nx;
            r_pend_side <= w_pend_side_nx;
            r_ptr       <= w_ptr_nx;
            r_busy      <= (w_state_nx != S_IDLE);
            r_armed     <= 1'b1;
        end
    end

    // enables follow run directly; r_armed keeps the motors off through reset
    assign bus.Le   = ~(bus.run & r_armed);
    assign bus.Re   = ~(bus.run & r_armed);
    assign bus.Ldir = (r_state == S_IDLE) || (r_state == S_TURN_R);
    assign bus.Rdir = (r_state == S_IDLE) || (r_state == S_TURN_L);
    assign bus.busy = r_busy;

    assign bus.dbg_state     = r_state;
    assign bus.dbg_pending   = r_pending;
    assign bus.dbg_pend_side = r_pend_side;
    assign bus.dbg_ptr       = r_ptr;

`ifdef MANEUVER_COUNT_EN
    logic [7:0] r_mcnt;
    logic       w_turn_done;

    assign w_turn_done = bus.run && w_phase_end &&
                         ((r_state == S_TURN_L) || (r_state == S_TURN_R));

    // saturating count of completed turn phases
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_mcnt <= 8'd0;
        else if (w_turn_done && (r_mcnt != 8'hFF))
            r_mcnt <= r_mcnt + 8'd1;
    end

    assign bus.maneuver_cnt = r_mcnt;
`else
    assign bus.maneuver_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_bump_maneuver_sequencer.sv
// Directed bench for bump_maneuver_sequencer with TICK_DIV=4, BACK_TICKS=3,
// TURN_TICKS=2 and DEB_CYCLES=2. Each table row applies inputs, waits n clocks
// and compares the full output/debug picture 1 ns after the edge.
module tb_bump_maneuver_sequencer;
    localparam logic [1:0] ST_I  = 2'd0;
    localparam logic [1:0] ST_B  = 2'd1;
    localparam logic [1:0] ST_TL = 2'd2;
    localparam logic [1:0] ST_TR = 2'd3;
`ifdef MANEUVER_COUNT_EN
    localparam bit MC_ON = 1'b1;
`else
    localparam bit MC_ON = 1'b0;
`endif

    typedef struct {
        bit         rst;
        bit         run;
        bit         rb;
        bit         lb;
        int         n;
        logic [1:0] st;
        logic       le;
        logic       pend;
        logic       pside;
        logic       ptr;
        logic [7:0] mc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    vec_t vecs [$];

    bump_maneuver_sequencer_if bus ();

    bump_maneuver_sequencer #(
        .TICK_DIV   (4),
        .BACK_TICKS (3),
        .TURN_TICKS (2),
        .DEB_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] dir_of(input logic [1:0] st);
        case (st)
            ST_I:    dir_of = 2'b11;
            ST_B:    dir_of = 2'b00;
            ST_TL:   dir_of = 2'b01;
            default: dir_of = 2'b10;
        endcase
    endfunction

    function automatic logic [17:0] actual_vec();
        actual_vec = {bus.dbg_state, bus.Le, bus.Re, bus.Ldir, bus.Rdir, bus.busy,
                      bus.dbg_pending, bus.dbg_pending & bus.dbg_pend_side,
                      bus.dbg_ptr, bus.maneuver_cnt};
    endfunction

    function automatic logic [17:0] expect_vec(input logic [1:0] st, input logic le,
                                               input logic pend, input logic pside,
                                               input logic ptr, input logic [7:0] mc);
        logic [1:0] d;
        d = dir_of(st);
        expect_vec = {st, le, le, d[1], d[0], (st != ST_I), pend, pend & pside, ptr,
                      MC_ON ? mc : 8'd0};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got st/Le/Re/Ld/Rd/busy/pend/pside/ptr/cnt=%b_%b%b%b%b%b_%b%b%b_%h required %b_%b%b%b%b%b_%b%b%b_%h",
                     name, act[17:16], act[15], act[14], act[13], act[12], act[11],
                     act[10], act[9], act[8], act[7:0],
                     exp[17:16], exp[15], exp[14], exp[13], exp[12], exp[11],
                     exp[10], exp[9], exp[8], exp[7:0]);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick_n(2);
        reset = 1'b1;
    endtask

    task automatic add(input bit rst, input bit run, input bit rb, input bit lb, input int n,
                       input logic [1:0] st, input logic le, input logic pend,
                       input logic pside, input logic ptr, input logic [7:0] mc);
        vec_t v;
        v.rst = rst; v.run = run; v.rb = rb; v.lb = lb; v.n = n;
        v.st = st; v.le = le; v.pend = pend; v.pside = pside; v.ptr = ptr; v.mc = mc;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // right hit, 10 low cycles: BACK 12 cycles, TURN_L 8 cycles
        add(0,1,0,1, 4, ST_I, 0,0,0,0, 0);
        add(0,1,0,1, 1, ST_B, 0,0,0,0, 0);
        add(0,1,0,1, 5, ST_B, 0,0,0,0, 0);
        add(0,1,1,1, 6, ST_B, 0,0,0,0, 0);
        add(0,1,1,1, 1, ST_TL,0,0,0,0, 0);
        add(0,1,1,1, 7, ST_TL,0,0,0,0, 0);
        add(0,1,1,1, 1, ST_I, 0,0,0,0, 1);
        // left glitch of 1 cycle rejected; 3 low cycles give a TURN_R maneuver
        add(0,1,1,0, 1, ST_I, 0,0,0,0, 1);
        add(0,1,1,1, 6, ST_I, 0,0,0,0, 1);
        add(0,1,1,0, 3, ST_I, 0,0,0,0, 1);
        add(0,1,1,1, 2, ST_B, 0,0,0,0, 1);
        add(0,1,1,1,11, ST_B, 0,0,0,0, 1);
        add(0,1,1,1, 1, ST_TR,0,0,0,0, 1);
        add(0,1,1,1, 7, ST_TR,0,0,0,0, 1);
        add(0,1,1,1, 1, ST_I, 0,0,0,0, 2);
        // simultaneous hit after reset: right first, left back-to-back, pointer -> left
        add(1,1,0,0, 3, ST_I, 0,0,0,0, 0);
        add(0,1,1,1, 2, ST_B, 0,1,1,1, 0);
        add(0,1,1,1,12, ST_TL,0,1,1,1, 0);
        add(0,1,1,1, 8, ST_B, 0,0,0,1, 1);
        add(0,1,1,1,12, ST_TR,0,0,0,1, 1);
        add(0,1,1,1, 8, ST_I, 0,0,0,1, 2);
        // second simultaneous hit: left first, pointer back to right
        add(0,1,0,0, 3, ST_I, 0,0,0,1, 2);
        add(0,1,1,1, 2, ST_B, 0,1,0,0, 2);
        add(0,1,1,1,12, ST_TR,0,1,0,0, 2);
        add(0,1,1,1, 8, ST_B, 0,0,0,0, 3);
        add(0,1,1,1,12, ST_TL,0,0,0,0, 3);
        add(0,1,1,1, 8, ST_I, 0,0,0,0, 4);
        // left hit during BACK, then right hit overwrites the pending side
        add(0,1,0,1, 3, ST_I, 0,0,0,0, 4);
        add(0,1,1,1, 2, ST_B, 0,0,0,0, 4);
        add(0,1,1,0, 3, ST_B, 0,0,0,0, 4);
        add(0,1,1,1, 2, ST_B, 0,1,1,0, 4);
        add(0,1,0,1, 3, ST_B, 0,1,1,0, 4);
        add(0,1,1,1, 2, ST_B, 0,1,0,0, 4);
        add(0,1,1,1, 2, ST_TL,0,1,0,0, 4);
        add(0,1,1,1, 8, ST_B, 0,0,0,0, 5);
        add(0,1,1,1,12, ST_TL,0,0,0,0, 5);
        add(0,1,1,1, 8, ST_I, 0,0,0,0, 6);
        // run dropped mid-TURN with a pending hit; presses while run=0 ignored
        add(0,1,0,1, 3, ST_I, 0,0,0,0, 6);
        add(0,1,1,1, 2, ST_B, 0,0,0,0, 6);
        add(0,1,1,0, 3, ST_B, 0,0,0,0, 6);
        add(0,1,1,1, 9, ST_TL,0,1,1,0, 6);
        add(0,1,1,1, 3, ST_TL,0,1,1,0, 6);
        add(0,0,1,1, 1, ST_I, 1,0,0,0, 6);
        add(0,0,0,1, 5, ST_I, 1,0,0,0, 6);
        add(0,1,1,1, 1, ST_I, 0,0,0,0, 6);
        add(0,1,1,1,20, ST_I, 0,0,0,0, 6);

        // reset held low: motors off, forward directions, everything cleared
        reset      = 1'b0;
        bus.run    = 1'b1;
        bus.R_bump = 1'b1;
        bus.L_bump = 1'b1;
        tick_n(3);
        check("reset_held", actual_vec(), expect_vec(ST_I, 1, 0, 0, 0, 0));
        reset = 1'b1;
        tick_n(2);
        check("idle_forward", actual_vec(), expect_vec(ST_I, 0, 0, 0, 0, 0));

        // enables respond to run without waiting for a clock edge
        #2 bus.run = 1'b0;
        #1 check("run_low_comb", actual_vec(), expect_vec(ST_I, 1, 0, 0, 0, 0));
        bus.run = 1'b1;
        #1 check("run_high_comb", actual_vec(), expect_vec(ST_I, 0, 0, 0, 0, 0));
        tick_n(3);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst)
                do_reset();
            bus.run    = vecs[i].run;
            bus.R_bump = vecs[i].rb;
            bus.L_bump = vecs[i].lb;
            tick_n(vecs[i].n);
            check($sformatf("row%0d", i), actual_vec(),
                  expect_vec(vecs[i].st, vecs[i].le, vecs[i].pend, vecs[i].pside,
                             vecs[i].ptr, vecs[i].mc));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bump_maneuver_sequencer.md
Name: bump_maneuver_sequencer

Overview:
Timed motor-command sequencer for the two-bumper robot board. It synchronises and debounces the active-low bump switches and arbitrates between left and right hits. It runs a forward / reverse / turn maneuver with exact tick-based phase durations and drives the L298-style enable and direction lines. It replaces the free-running slow-clock FSM: everything runs on the 2.08 MHz oscillator clock, and an internal tick divider replaces the derived clock.

Parameters:
TICK_DIV, 20800, clk cycles per phase tick (default 10 ms at 2.08 MHz); legal range 2..2^20
BACK_TICKS, 50, ticks spent reversing; legal range 1..255
TURN_TICKS, 40, ticks spent turning; legal range 1..255
DEB_CYCLES, 2080, consecutive synchronised-low clk samples that qualify a bump; legal range 1..2^16

Ports:
clk  input  1  oscillator clock, sole clock domain
reset  input  1  asynchronous active-low reset
run  input  1  1 = motors may drive; 0 = motors off, sequencer parked in IDLE
R_bump  input  1  right bumper, active-low, asynchronous to clk
L_bump  input  1  left bumper, active-low, asynchronous to clk
Le  output  1  left motor enable, active-low (0 = driven)
Re  output  1  right motor enable, active-low
Ldir  output  1  left direction, 1 = forward
Rdir  output  1  right direction, 1 = forward
busy  output  1  1 while in BACK or TURN
maneuver_cnt  output  8  completed maneuvers; see Optional Feature

Behaviour:
- Reset (asynchronous, active-low) values:
  - state IDLE; Le=Re=1; Ldir=Rdir=1; busy=0; maneuver_cnt=0.
  - pending=0; priority pointer = right; all counters 0; sync flops = 1.
- Input conditioning:
  - Each bump passes through a 2-flop synchroniser, then a per-side debounce counter.
  - The event flag for a side sets when the counter reaches DEB_CYCLES consecutive low samples.
  - Any high sample clears that side's counter and event flag.
  - A request is the rising edge of the event flag: one pulse per press.
- Tick: the divider counts 0..TICK_DIV-1 and pulses tick when it wraps. It restarts from 0 on every phase entry, so each phase lasts exactly N*TICK_DIV cycles. A phase-tick counter (8 bits) also clears on phase entry.
- States and outputs:
  - IDLE: forward. Le=Re=0 when run=1, else Le=Re=1. Ldir=Rdir=1.
  - BACK: Le=Re=0; Ldir=Rdir=0.
  - TURN_L (after a right hit): Le=Re=0; Ldir=0; Rdir=1.
  - TURN_R (after a left hit): Le=Re=0; Ldir=1; Rdir=0.
- Transitions:
  - IDLE -> BACK on the clk edge after a request with run=1. The side is latched in side_q.
  - BACK -> TURN_x on the BACK_TICKS-th tick after entry, where x is chosen from side_q.
  - TURN_x -> IDLE on the TURN_TICKS-th tick, unless pending=1. With pending=1, go directly to BACK with side_q <= pending side and clear pending.
- Arbitration:
  - Both sides requesting in the same cycle: the side indicated by the priority pointer wins, and the pointer then toggles.
  - The losing side is stored as pending.
  - A single-side request leaves the pointer unchanged.
- Pending: 1-deep. Requests arriving during BACK/TURN set pending (side recorded). A further request while pending=1 overwrites the pending side; it never queues deeper.
- Re-hit of the same side during BACK does not restart the phase; it becomes pending.
- run=0 in any state:
  - Next edge: state -> IDLE; pending cleared; Le=Re=1 (combinational on run).
  - Requests are ignored while run=0.
  - The debounce counters keep running.
- busy = (state != IDLE), registered with the state.
- All outputs are decoded from registered state/side plus run; no glitch paths from the bump pins.

Optional Feature:
- Macro: MANEUVER_COUNT_EN
- Defined:
  - maneuver_cnt increments by 1 on every TURN_x exit, whether to IDLE or to BACK.
  - Saturates at 255.
  - Cleared only by reset.
- Undefined: maneuver_cnt is tied to 8'd0 and its counter logic is not instantiated.

Test Plan:
All scenarios use TICK_DIV=4, BACK_TICKS=3, TURN_TICKS=2, DEB_CYCLES=2, run=1 unless stated otherwise.
- Reset, then idle with no bumps -> Le=Re=0, Ldir=Rdir=1, busy=0; with reset held low, Le=Re=1.
- R_bump low for 10 cycles -> BACK (Ldir=Rdir=0) for exactly 12 cycles, then TURN_L (Ldir=0, Rdir=1) for 8 cycles, then IDLE; maneuver_cnt=1 with MANEUVER_COUNT_EN defined.
- L_bump low for 1 cycle only -> no state change (debounce reject); low for 3 cycles -> maneuver with TURN_R.
- R_bump and L_bump fall in the same cycle after reset -> right serviced first, then BACK -> TURN_R with no IDLE gap; pointer = left; a second simultaneous hit services left first.
- L hit during BACK of a right maneuver, then R hit while pending -> after TURN_L, pending side = right (overwrite); total maneuvers = 2.
- run dropped mid-TURN -> next edge IDLE, Le=Re=1, busy=0, pending cleared; run=1 restores forward drive with no queued maneuver.
